// File: rtl/serial_seq_checker_pkg.sv
// Shared types and default constants for the serial sequence checker.
// Holds the checker state encoding and the default frame definition.
package serial_seq_checker_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   localparam int          SEQ_LEN_DEF   = 10;
   localparam logic [15:0] PATTERN_DEF   = 16'h003F;
   localparam int          ALIGN_IDX_DEF = 6;

   // Index expected for the sample that follows the alignment edge.
   function automatic logic [3:0] align_load_idx(input int align_idx, input int seq_len);
      return 4'((align_idx + 1) % seq_len);
   endfunction

endpackage

// File: rtl/seq_index_counter.sv
// Synchronous mod-SEQ_LEN frame index counter with clear, alignment load
// and advance controls (priority in that order) plus a last-index flag.
module seq_index_counter
   import serial_seq_checker_pkg::*;
#(
   parameter int SEQ_LEN   = SEQ_LEN_DEF,
   parameter int ALIGN_IDX = ALIGN_IDX_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       adv,
   input  logic       load,
   input  logic       clr,
   output logic [3:0] idx,
   output logic       last
);

   localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);
   localparam logic [3:0] LOAD_VAL = align_load_idx(ALIGN_IDX, SEQ_LEN);

   logic [3:0] idx_q;
   logic [3:0] idx_d;

   always_comb begin
      idx_d = idx_q;
      if (clr) begin
         idx_d = 4'd0;
      end else if (load) begin
         idx_d = LOAD_VAL;
      end else if (adv) begin
         idx_d = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= 4'd0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx  = idx_q;
   assign last = (idx_q == LAST_IDX);

endmodule

// File: rtl/serial_seq_checker.sv
// Serial pattern checker: hunts for the 1->0 alignment edge, verifies whole
// frames before declaring lock, then flags and counts bit errors while locked.
module serial_seq_checker
   import serial_seq_checker_pkg::*;
#(
   parameter int          SEQ_LEN   = SEQ_LEN_DEF,
   parameter logic [15:0] PATTERN   = PATTERN_DEF,
   parameter int          ALIGN_IDX = ALIGN_IDX_DEF,
   parameter int          LOCK_CNT  = 2,
   parameter int          ERR_LIMIT = 3,
   parameter int          ERR_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             din,
   input  logic             clr_err,
   output logic             locked,
   output logic [3:0]       idx,
   output logic             bit_err,
   output logic             frame_done,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       dbg_state
);

   localparam int GF_W = $clog2(LOCK_CNT + 1);
   localparam int MC_W = $clog2(ERR_LIMIT + 1);

   state_e           state_q, state_d;
   logic             prev_bit_q, prev_bit_d;
   logic [GF_W-1:0]  good_frames_q, good_frames_d;
   logic [MC_W-1:0]  miss_cnt_q, miss_cnt_d;
   logic             frame_bad_q, frame_bad_d;
   logic             locked_q, locked_d;
   logic             bit_err_q, bit_err_d;
   logic             frame_done_q, frame_done_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;

   logic cnt_adv, cnt_load, cnt_clr, cnt_last;
   logic mismatch;

   seq_index_counter #(
      .SEQ_LEN  (SEQ_LEN),
      .ALIGN_IDX(ALIGN_IDX)
   ) u_idx (
      .clk  (clk),
      .rst_n(rst_n),
      .adv  (cnt_adv),
      .load (cnt_load),
      .clr  (cnt_clr),
      .idx  (idx),
      .last (cnt_last)
   );

   assign mismatch = (din != PATTERN[idx]);

   always_comb begin
      state_d       = state_q;
      prev_bit_d    = prev_bit_q;
      good_frames_d = good_frames_q;
      miss_cnt_d    = miss_cnt_q;
      frame_bad_d   = frame_bad_q;
      locked_d      = locked_q;
      bit_err_d     = 1'b0;
      frame_done_d  = 1'b0;
      err_count_d   = err_count_q;
      cnt_adv       = 1'b0;
      cnt_load      = 1'b0;
      cnt_clr       = 1'b0;
      if (en) begin
         prev_bit_d = din;
         case (state_q)
            ST_HUNT: begin
               if (prev_bit_q && !din) begin
                  cnt_load      = 1'b1;
                  good_frames_d = '0;
                  state_d       = ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (mismatch) begin
                  cnt_clr = 1'b1;
                  state_d = ST_HUNT;
               end else begin
                  cnt_adv = 1'b1;
                  if (cnt_last) begin
                     frame_done_d  = 1'b1;
                     good_frames_d = good_frames_q + GF_W'(1);
                     if (good_frames_q == GF_W'(LOCK_CNT - 1)) begin
                        state_d     = ST_LOCKED;
                        locked_d    = 1'b1;
                        miss_cnt_d  = '0;
                        frame_bad_d = 1'b0;
                     end
                  end
               end
            end
            ST_LOCKED: begin
               if (mismatch) begin
                  bit_err_d = 1'b1;
                  if (err_count_q != {ERR_W{1'b1}}) begin
                     err_count_d = err_count_q + ERR_W'(1);
                  end
                  if (miss_cnt_q == MC_W'(ERR_LIMIT - 1)) begin
                     cnt_clr     = 1'b1;
                     state_d     = ST_HUNT;
                     locked_d    = 1'b0;
                     miss_cnt_d  = '0;
                     frame_bad_d = 1'b0;
                  end else begin
                     cnt_adv     = 1'b1;
                     miss_cnt_d  = miss_cnt_q + MC_W'(1);
                     frame_bad_d = !cnt_last;
                  end
               end else begin
                  cnt_adv = 1'b1;
                  if (cnt_last) begin
                     frame_done_d = 1'b1;
                     frame_bad_d  = 1'b0;
                     // Only an error-free frame forgives earlier misses.
                     if (!frame_bad_q) begin
                        miss_cnt_d = '0;
                     end
                  end
               end
            end
            default: begin
               cnt_clr  = 1'b1;
               state_d  = ST_HUNT;
               locked_d = 1'b0;
            end
         endcase
      end
      if (clr_err) begin
         err_count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_HUNT;
         prev_bit_q    <= 1'b0;
         good_frames_q <= '0;
         miss_cnt_q    <= '0;
         frame_bad_q   <= 1'b0;
         locked_q      <= 1'b0;
         bit_err_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         prev_bit_q    <= prev_bit_d;
         good_frames_q <= good_frames_d;
         miss_cnt_q    <= miss_cnt_d;
         frame_bad_q   <= frame_bad_d;
         locked_q      <= locked_d;
         bit_err_q     <= bit_err_d;
         frame_done_q  <= frame_done_d;
         err_count_q   <= err_count_d;
      end
   end

   assign locked     = locked_q;
   assign bit_err    = bit_err_q;
   assign frame_done = frame_done_q;
   assign err_count  = err_count_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_seq_checker.sv
// Bench for serial_seq_checker: lock-acquisition vector table, directed
// error/loss/reset sequences and a randomized stream against a reference model.
module tb_serial_seq_checker;
   import serial_seq_checker_pkg::*;

   localparam int          L         = 10;
   localparam logic [15:0] PAT       = 16'h003F;
   localparam int          ALIGN     = 6;
   localparam int          LOCK_CNT  = 2;
   localparam int          ERR_LIMIT = 3;
   localparam int          ERR_W     = 8;
   localparam int          ERR_MAX   = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             din;
   logic             clr_err;
   logic             locked;
   logic [3:0]       idx;
   logic             bit_err;
   logic             frame_done;
   logic [ERR_W-1:0] err_count;
   logic [1:0]       dbg_state;

   always #5 clk = ~clk;

   serial_seq_checker #(
      .SEQ_LEN  (L),
      .PATTERN  (PAT),
      .ALIGN_IDX(ALIGN),
      .LOCK_CNT (LOCK_CNT),
      .ERR_LIMIT(ERR_LIMIT),
      .ERR_W    (ERR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .din       (din),
      .clr_err   (clr_err),
      .locked    (locked),
      .idx       (idx),
      .bit_err   (bit_err),
      .frame_done(frame_done),
      .err_count (err_count),
      .dbg_state (dbg_state)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit pat_bit(input int i);
      logic [15:0] p;
      p = PAT;
      return p[i];
   endfunction

   // Reference model: frame position and counters kept as plain integers.
   state_e m_state;
   int     m_idx, m_good, m_miss, m_err;
   bit     m_prev, m_frame_bad, m_bit_err, m_fd;

   task automatic model_reset();
      m_state = ST_HUNT; m_idx = 0; m_good = 0; m_miss = 0; m_err = 0;
      m_prev = 0; m_frame_bad = 0; m_bit_err = 0; m_fd = 0;
   endtask

   task automatic model_step(input bit e, input bit d, input bit c);
      bit wrong, at_end;
      m_bit_err = 0;
      m_fd      = 0;
      if (e) begin
         wrong  = (d != pat_bit(m_idx));
         at_end = (m_idx == L - 1);
         if (m_state == ST_HUNT) begin
            if (m_prev && !d) begin
               m_state = ST_VERIFY;
               m_idx   = (ALIGN + 1) % L;
               m_good  = 0;
            end
         end else if (m_state == ST_VERIFY) begin
            if (wrong) begin
               m_state = ST_HUNT;
               m_idx   = 0;
            end else begin
               if (at_end) begin
                  m_fd = 1;
                  m_good++;
                  if (m_good == LOCK_CNT) begin
                     m_state = ST_LOCKED; m_miss = 0; m_frame_bad = 0;
                  end
               end
               m_idx = (m_idx + 1) % L;
            end
         end else begin
            if (wrong) begin
               m_bit_err = 1;
               if (m_err < ERR_MAX) m_err++;
               m_miss++;
               m_frame_bad = 1;
            end
            if (m_miss == ERR_LIMIT) begin
               m_state = ST_HUNT; m_idx = 0; m_miss = 0; m_frame_bad = 0;
            end else begin
               if (at_end) begin
                  if (!wrong) m_fd = 1;
                  if (!m_frame_bad) m_miss = 0;
                  m_frame_bad = 0;
               end
               m_idx = (m_idx + 1) % L;
            end
         end
         m_prev = d;
      end
      if (c) m_err = 0;
   endtask

   task automatic check_model();
      check("locked", locked, (m_state == ST_LOCKED));
      check("idx", idx, m_idx);
      check("bit_err", bit_err, m_bit_err);
      check("frame_done", frame_done, m_fd);
      check("err_count", err_count, m_err);
      check("state", dbg_state, m_state);
   endtask

   task automatic step(input bit e, input bit d, input bit c);
      en = e; din = d; clr_err = c;
      @(posedge clk);
      #1;
      model_step(e, d, c);
      check_model();
   endtask

   int gen_idx;

   // One sample of the generator stream, optionally inverted.
   task automatic gen1(input bit flip, input bit c);
      step(1'b1, pat_bit(gen_idx) ^ flip, c);
      gen_idx = (gen_idx + 1) % L;
   endtask

   task automatic gen(input int n, input logic [15:0] flip_mask);
      for (int k = 0; k < n; k++) gen1(flip_mask[gen_idx], 1'b0);
   endtask

   task automatic do_reset();
      en = 0; din = 0; clr_err = 0;
      #3 rst_n = 0;
      #12 rst_n = 1;
      model_reset();
      @(negedge clk);
   endtask

   typedef struct {
      bit     en;
      bit     din;
      bit     clr;
      state_e exp_state;
      int     exp_idx;
      bit     exp_fd;
      bit     exp_locked;
   } vec_t;

   vec_t vecs[17];

   initial begin
      vecs[0]  = '{1, 1, 0, ST_HUNT,   0, 0, 0};
      vecs[1]  = '{1, 1, 0, ST_HUNT,   0, 0, 0};
      vecs[2]  = '{1, 1, 0, ST_HUNT,   0, 0, 0};
      vecs[3]  = '{1, 0, 0, ST_VERIFY, 7, 0, 0};
      vecs[4]  = '{1, 0, 0, ST_VERIFY, 8, 0, 0};
      vecs[5]  = '{1, 0, 0, ST_VERIFY, 9, 0, 0};
      vecs[6]  = '{1, 0, 0, ST_VERIFY, 0, 1, 0};
      vecs[7]  = '{1, 1, 0, ST_VERIFY, 1, 0, 0};
      vecs[8]  = '{1, 1, 0, ST_VERIFY, 2, 0, 0};
      vecs[9]  = '{1, 1, 0, ST_VERIFY, 3, 0, 0};
      vecs[10] = '{1, 1, 0, ST_VERIFY, 4, 0, 0};
      vecs[11] = '{1, 1, 0, ST_VERIFY, 5, 0, 0};
      vecs[12] = '{1, 1, 0, ST_VERIFY, 6, 0, 0};
      vecs[13] = '{1, 0, 0, ST_VERIFY, 7, 0, 0};
      vecs[14] = '{1, 0, 0, ST_VERIFY, 8, 0, 0};
      vecs[15] = '{1, 0, 0, ST_VERIFY, 9, 0, 0};
      vecs[16] = '{1, 0, 0, ST_LOCKED, 0, 1, 1};

      rst_n = 1; en = 0; din = 0; clr_err = 0;
      model_reset();
      do_reset();
      check("rst_locked", locked, 0);
      check("rst_idx", idx, 0);
      check("rst_err_count", err_count, 0);
      check("rst_state", dbg_state, ST_HUNT);

      // Alignment and lock from a stream starting at index 3.
      foreach (vecs[k]) begin
         step(vecs[k].en, vecs[k].din, vecs[k].clr);
         check($sformatf("tbl%0d_state", k), dbg_state, vecs[k].exp_state);
         check($sformatf("tbl%0d_idx", k), idx, vecs[k].exp_idx);
         check($sformatf("tbl%0d_fd", k), frame_done, vecs[k].exp_fd);
         check($sformatf("tbl%0d_locked", k), locked, vecs[k].exp_locked);
         check($sformatf("tbl%0d_bit_err", k), bit_err, 0);
      end
      gen_idx = 0;

      // Single error, then a clean frame must clear the miss count so
      // two errors in a later frame do not drop lock.
      gen(10, 16'h0004);
      check("single_err_count", err_count, 1);
      check("single_locked", locked, 1);
      gen(10, 16'h0000);
      gen(10, 16'h0028);
      check("miss_cleared_locked", locked, 1);
      check("miss_cleared_err", err_count, 3);

      // Clear, one clean frame, then three errors in one frame.
      gen1(1'b0, 1'b1);
      check("clr_err_count", err_count, 0);
      gen(9, 16'h0000);
      gen(9, 16'h0112);
      check("loss_locked", locked, 0);
      check("loss_idx", idx, 0);
      check("loss_state", dbg_state, ST_HUNT);
      check("loss_err_count", err_count, 3);

      // VERIFY failure: align then corrupt index 8.
      do_reset();
      gen_idx = 3;
      gen(5, 16'h0000);
      check("vfy_state", dbg_state, ST_VERIFY);
      gen1(1'b1, 1'b0);
      check("vfy_fail_state", dbg_state, ST_HUNT);
      check("vfy_fail_bit_err", bit_err, 0);
      check("vfy_fail_err", err_count, 0);
      check("vfy_fail_locked", locked, 0);

      // Relock, then en gaps and clear colliding with an increment.
      gen(30, 16'h0000);
      check("relock", locked, 1);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         check("gap_bit_err", bit_err, 0);
         check("gap_fd", frame_done, 0);
      end
      gen1(1'b1, 1'b1);
      check("coinc_bit_err", bit_err, 1);
      check("coinc_err_count", err_count, 0);

      // Randomized stream with gaps, rare bit flips and clears.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 9) < 7) begin
            gen1(($urandom_range(0, 24) == 0), ($urandom_range(0, 29) == 0));
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
         end
      end

      // Async reset mid-frame while locked, between clock edges.
      gen(35, 16'h0000);
      check("pre_reset_locked", locked, 1);
      #2 rst_n = 0;
      #1;
      check("async_locked", locked, 0);
      check("async_idx", idx, 0);
      check("async_err", err_count, 0);
      check("async_state", dbg_state, ST_HUNT);
      model_reset();
      #10 rst_n = 1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
      check("no_edge_state", dbg_state, ST_HUNT);
      gen_idx = 0;
      gen(30, 16'h0000);
      check("relock_after_reset", locked, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
